// File: rtl/mdu_iter_unit_pkg.sv
// Shared constants, FSM state type and opcode decode for the iterative multiply/divide unit.
package mdu_iter_unit_pkg;

    localparam int MDU_INFO_W = 8;

    localparam int MDU_MUL    = 0;
    localparam int MDU_MULH   = 1;
    localparam int MDU_MULHSU = 2;
    localparam int MDU_MULHU  = 3;
    localparam int MDU_DIV    = 4;
    localparam int MDU_DIVU   = 5;
    localparam int MDU_REM    = 6;
    localparam int MDU_REMU   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    typedef struct packed {
        logic legal;
        logic is_mul;
        logic is_div;
        logic signed_a;
        logic signed_b;
        logic want_hi;
        logic want_rem;
    } mdu_dec_t;

    function automatic mdu_dec_t decode_op(input logic [MDU_INFO_W-1:0] info);
        mdu_dec_t d;
        d.legal    = $onehot(info);
        d.is_mul   = info[MDU_MUL] | info[MDU_MULH] | info[MDU_MULHSU] | info[MDU_MULHU];
        d.is_div   = info[MDU_DIV] | info[MDU_DIVU] | info[MDU_REM] | info[MDU_REMU];
        d.signed_a = info[MDU_MULH] | info[MDU_MULHSU] | info[MDU_DIV] | info[MDU_REM];
        d.signed_b = info[MDU_MULH] | info[MDU_DIV] | info[MDU_REM];
        d.want_hi  = info[MDU_MULH] | info[MDU_MULHSU] | info[MDU_MULHU];
        d.want_rem = info[MDU_REM] | info[MDU_REMU];
        return d;
    endfunction

endpackage

// File: rtl/mdu_iter_unit_if.sv
// Issue/result handshake bundle between the E stage and the multiply/divide unit.
interface mdu_iter_unit_if
    import mdu_iter_unit_pkg::*;
#(
    parameter int XLEN = 64
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [MDU_INFO_W-1:0] mdu_info_i;
    logic [XLEN-1:0]       E_valA_i;
    logic [XLEN-1:0]       E_valB_i;
    logic                  flush_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [XLEN-1:0]       e_valM_o;
    logic                  busy_o;

    modport slave (
        input  in_valid_i, mdu_info_i, E_valA_i, E_valB_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, e_valM_o, busy_o
    );

    modport master (
        output in_valid_i, mdu_info_i, E_valA_i, E_valB_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, e_valM_o, busy_o
    );
endinterface

// File: rtl/mdu_iter_unit_dp.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring shift-subtract divide on magnitudes.
module mdu_iter_dp #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_prod,
    output logic [XLEN-1:0]   o_quo,
    output logic [XLEN-1:0]   o_rem
);
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_rem;

    logic [XLEN-1:0] w_addend;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_trial;
    logic [XLEN:0]   w_diff;
    logic            w_fits;

    // Multiplier sits in the low half of the accumulator and is consumed LSB first.
    assign w_addend = r_acc[0] ? r_opnd : '0;
    assign w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};

    // Remainder stays below the divisor, so a set MSB of the difference means "does not fit".
    assign w_trial = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_trial - {1'b0, r_opnd};
    assign w_fits  = ~w_diff[XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
        end else if (i_start) begin
            r_acc  <= {{XLEN{1'b0}}, i_b};
            r_opnd <= i_is_div ? i_b : i_a;
            r_quo  <= i_a;
            r_rem  <= '0;
        end else if (i_step) begin
            if (i_is_div) begin
                r_rem <= w_fits ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
                r_quo <= {r_quo[XLEN-2:0], w_fits};
            end else begin
                r_acc <= {w_sum, r_acc[XLEN-1:1]};
            end
        end
    end

    assign o_prod = r_acc;
    assign o_quo  = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/mdu_iter_unit.sv
// Iterative RISC-V M-extension execute unit: FSM, counter, handshakes and sign/special-case fix-up.
// Define MDU_EARLY_OUT_EN to short-cut divide-by-zero, signed overflow and zero-operand multiplies.
module mdu_iter_unit
    import mdu_iter_unit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic           clk,
    input  logic           rst,
    mdu_iter_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t            r_state;
    logic [MDU_INFO_W-1:0] r_op;
    logic [XLEN-1:0]       r_a;
    logic [XLEN-1:0]       r_b;
    logic [XLEN-1:0]       r_result;
    logic                  r_out_valid;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_neg_res;
    logic                  r_neg_rem;

    mdu_dec_t          w_dec;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic              w_mul_zero;
    logic [CNT_W-1:0]  w_cnt_load;
    logic              w_start;
    logic              w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_result;

    assign w_dec   = decode_op(r_op);
    assign w_sa    = w_dec.signed_a & r_a[XLEN-1];
    assign w_sb    = w_dec.signed_b & r_b[XLEN-1];
    assign w_a_mag = w_sa ? -r_a : r_a;
    assign w_b_mag = w_sb ? -r_b : r_b;

    assign w_div0     = w_dec.is_div & (r_b == '0);
    assign w_ovf      = w_dec.is_div & w_dec.signed_b & (r_a == MOST_NEG) & (&r_b);
    assign w_mul_zero = w_dec.is_mul & ((r_a == '0) | (r_b == '0));

`ifdef MDU_EARLY_OUT_EN
    logic w_special;
    assign w_special  = w_dec.legal & (w_div0 | w_ovf | w_mul_zero);
    // A zero count makes CALC fall straight through to DONE on its first cycle.
    assign w_cnt_load = w_special ? '0 : CNT_LOAD;
`else
    assign w_cnt_load = CNT_LOAD;
`endif

    assign w_start = (r_state == ST_PREP);
    assign w_step  = (r_state == ST_CALC) && (r_cnt != '0);

    mdu_iter_dp #(
        .XLEN (XLEN)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_step   (w_step),
        .i_is_div (w_dec.is_div),
        .i_a      (w_a_mag),
        .i_b      (w_b_mag),
        .o_prod   (w_prod),
        .o_quo    (w_quo),
        .o_rem    (w_rem)
    );

    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_res ? -w_quo : w_quo;
    assign w_rem_fix  = r_neg_rem ? -w_rem : w_rem;

    // Special cases are forced here so both builds return identical values.
    always_comb begin
        w_result = '0;
        if (w_dec.legal) begin
            if (w_dec.is_div) begin
                if (w_div0) begin
                    w_result = w_dec.want_rem ? r_a : '1;
                end else if (w_ovf) begin
                    w_result = w_dec.want_rem ? '0 : r_a;
                end else begin
                    w_result = w_dec.want_rem ? w_rem_fix : w_quo_fix;
                end
            end else if (!w_mul_zero) begin
                w_result = w_dec.want_hi ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
        end else if (bus.flush_i && (r_state != ST_IDLE)) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid_i && !bus.flush_i) begin
                        r_op    <= bus.mdu_info_i;
                        r_a     <= bus.E_valA_i;
                        r_b     <= bus.E_valB_i;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_neg_res <= w_sa ^ w_sb;
                    r_neg_rem <= w_sa;
                    r_cnt     <= w_cnt_load;
                    r_state   <= ST_CALC;
                end
                ST_CALC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_result    <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = (r_state == ST_IDLE);
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.out_valid_o = r_out_valid;
    assign bus.e_valM_o    = r_result;

endmodule

// File: tb/tb_mdu_iter_unit.sv
// Directed plus randomized check of mdu_iter_unit against an arithmetic reference model.
module tb_mdu_iter_unit;
    import mdu_iter_unit_pkg::*;

    localparam int XLEN = 64;
    localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mdu_iter_unit_if #(.XLEN(XLEN)) bus ();

    mdu_iter_unit #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RISC-V M semantics from plain arithmetic on wide / signed values.
    function automatic logic [63:0] ref_model(input logic [7:0] info, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0] pa, pb, p;
        longint       sa, sb;
        sa = a;
        sb = b;
        case (info)
            8'h01: return a * b;
            8'h02: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
            8'h04: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b};       p = pa * pb; return p[127:64]; end
            8'h08: begin pa = {64'd0, a};       pb = {64'd0, b};       p = pa * pb; return p[127:64]; end
            8'h10: begin
                if (b == 64'd0) return ONES;
                if (a == MOST_NEG && b == ONES) return a;
                return 64'(sa / sb);
            end
            8'h20: begin
                if (b == 64'd0) return ONES;
                return a / b;
            end
            8'h40: begin
                if (b == 64'd0) return a;
                if (a == MOST_NEG && b == ONES) return 64'd0;
                return 64'(sa % sb);
            end
            8'h80: begin
                if (b == 64'd0) return a;
                return a % b;
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int exp_latency(input logic [7:0] info, input logic [63:0] a,
                                       input logic [63:0] b);
        bit is_mul, is_div, sgn_div, sp;
        is_mul  = |info[3:0];
        is_div  = |info[7:4];
        sgn_div = info[4] | info[6];
        sp = $onehot(info) && ((is_mul && (a == 64'd0 || b == 64'd0)) || (is_div && b == 64'd0) ||
                               (sgn_div && a == MOST_NEG && b == ONES));
        return (EARLY && sp) ? 2 : XLEN + 2;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return ONES;
            2:       return MOST_NEG;
            3:       return 64'd1;
            4:       return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run_op(input logic [7:0] info, input logic [63:0] a, input logic [63:0] b,
                          input int hold, input bit flush_done, input string tag);
        logic [63:0] exp;
        int          lat;
        int          n;
        bit          got;
        exp = ref_model(info, a, b);
        lat = exp_latency(info, a, b);
        @(negedge clk);
        check({tag, ":rdy"}, 64'(bus.in_ready_o), 64'd1);
        bus.in_valid_i  = 1'b1;
        bus.mdu_info_i  = info;
        bus.E_valA_i    = a;
        bus.E_valB_i    = b;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 4 * XLEN) begin
            @(negedge clk);
            n++;
            if (bus.out_valid_o) got = 1'b1;
        end
        check({tag, ":lat"}, 64'(n), 64'(lat));
        if (got) begin
            for (int i = 0; i < hold; i++) begin
                check({tag, ":hold"}, {bus.e_valM_o}, exp);
                check({tag, ":hold_rdy"}, {63'd0, bus.in_ready_o}, 64'd0);
                @(negedge clk);
            end
            check({tag, ":res"}, bus.e_valM_o, exp);
            bus.out_ready_i = 1'b1;
            bus.flush_i     = flush_done;
            @(negedge clk);
            bus.out_ready_i = 1'b0;
            bus.flush_i     = 1'b0;
            check({tag, ":idle"}, {62'd0, bus.in_ready_o, bus.out_valid_o}, 64'd2);
        end
        $display("[TB] %s info=%02h a=%h b=%h result=%h expected=%h latency=%0d",
                 tag, info, a, b, bus.e_valM_o, exp, n);
    endtask

    initial begin
        logic [7:0] info;
        bit         seen;
        n_tests = 0;
        n_fail  = 0;
        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.mdu_info_i  = '0;
        bus.E_valA_i    = '0;
        bus.E_valB_i    = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rdy", 64'(bus.in_ready_o), 64'd1);
        check("reset_vld", 64'(bus.out_valid_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_res", bus.e_valM_o, 64'd0);
        rst = 1'b0;

        run_op(8'h01, 64'd7, -64'sd3, 0, 1'b0, "mul_7x-3");
        run_op(8'h08, ONES, ONES, 0, 1'b0, "mulhu_ones");
        run_op(8'h02, -64'sd5, 64'd3, 0, 1'b0, "mulh_neg");
        run_op(8'h04, ONES, ONES, 0, 1'b0, "mulhsu");
        run_op(8'h10, -64'sd7, 64'd2, 0, 1'b0, "div_-7/2");
        run_op(8'h40, -64'sd7, 64'd2, 0, 1'b0, "rem_-7%2");
        run_op(8'h20, 64'd100, 64'd7, 0, 1'b0, "divu_100/7");
        run_op(8'h80, 64'd100, 64'd7, 0, 1'b0, "remu_100%7");
        run_op(8'h10, 64'd5, 64'd0, 0, 1'b0, "div_by0");
        run_op(8'h40, 64'd5, 64'd0, 0, 1'b0, "rem_by0");
        run_op(8'h10, MOST_NEG, ONES, 0, 1'b0, "div_ovf");
        run_op(8'h40, MOST_NEG, ONES, 0, 1'b0, "rem_ovf");
        run_op(8'h01, 64'd0, 64'd9, 0, 1'b0, "mul_zero");
        run_op(8'h00, 64'd6, 64'd7, 0, 1'b0, "illegal_zero");
        run_op(8'h03, 64'd6, 64'd7, 0, 1'b0, "illegal_multi");
        run_op(8'h01, 64'd11, 64'd13, 10, 1'b0, "backpressure");
        run_op(8'h20, 64'd50, 64'd5, 0, 1'b0, "after_bp");
        run_op(8'h01, 64'd2, 64'd2, 2, 1'b1, "flush_done");

        // Flush during the fifth CALC cycle.
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.mdu_info_i = 8'h01;
        bus.E_valA_i   = 64'd5;
        bus.E_valB_i   = 64'd5;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        check("flush_busy", 64'(bus.busy_o), 64'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_idle", {62'd0, bus.in_ready_o, bus.busy_o}, 64'd2);
        seen = 1'b0;
        repeat (XLEN + 5) begin
            @(negedge clk);
            if (bus.out_valid_o) seen = 1'b1;
        end
        check("flush_novalid", 64'(seen), 64'd0);
        run_op(8'h01, 64'd3, 64'd4, 0, 1'b0, "mul_after_flush");

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.flush_i    = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        check("idle_flush", 64'(bus.busy_o), 64'd0);

        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 9);
            info = (r < 8) ? (8'h01 << r) : 8'($urandom_range(0, 255));
            run_op(info, pick_operand(), pick_operand(), $urandom_range(0, 3), 1'b0, "rand");
        end

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.mdu_info_i = 8'h20;
        bus.E_valA_i   = 64'd1000;
        bus.E_valB_i   = 64'd3;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rdy", 64'(bus.in_ready_o), 64'd1);
        check("arst_vld", 64'(bus.out_valid_o), 64'd0);
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_res", bus.e_valM_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h01, 64'd3, 64'd4, 0, 1'b0, "mul_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
